// File: rtl/usb_tx_encoder_if.sv
// -----------------------------------------------------------------------------
// usb_tx_encoder_if
//
// Handshake and line bundle between the USB full-speed transmit encoder, its
// transmit FIFO (first-word-fall-through) and the bus pad drivers.
//
// Signals:
//   tx_start       one-cycle request to send a packet
//   fifo_r_data    head byte of the transmit FIFO (valid when fifo_empty=0)
//   fifo_empty     transmit FIFO empty flag
//   fifo_r_enable  one-cycle pop strobe back to the FIFO
//   dplus/dminus   D+/D- line drive
//   tx_busy        packet in flight
//   tx_done        one-cycle pulse when a packet finishes
//
// Modports:
//   master  packet source / FIFO side (drives the request and FIFO head)
//   slave   the encoder itself
// -----------------------------------------------------------------------------
interface usb_tx_encoder_if;
    logic       tx_start;
    logic [7:0] fifo_r_data;
    logic       fifo_empty;
    logic       fifo_r_enable;
    logic       dplus;
    logic       dminus;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output fifo_r_data,
        output fifo_empty,
        input  fifo_r_enable,
        input  dplus,
        input  dminus,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  fifo_r_data,
        input  fifo_empty,
        output fifo_r_enable,
        output dplus,
        output dminus,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// -----------------------------------------------------------------------------
// usb_tx_encoder
//
// Transmit-side line encoder for the USB full-speed path. On a start request
// it sends SYNC, then every byte the transmit FIFO holds (LSB first), then
// EOP (two bit periods of SE0, one of J) and returns to idle J. All logical
// bits go through bit stuffing (a 0 after six consecutive 1s) and NRZI
// (0 toggles J<->K, 1 holds the line).
//
// Optional feature (compile-time macro TX_CRC16_EN):
//   When defined, a CRC16 (poly 0x8005, init 0xFFFF, LSB-first) over the
//   payload is kept and its ones-complement is sent LSB first, stuffed and
//   NRZI-encoded, between the payload and EOP. When undefined there is no
//   CRC state or logic at all.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per USB bit period (>= 4)
//
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset (forces idle J at once, no EOP)
//   bus    usb_tx_encoder_if.slave: tx_start, fifo_r_data, fifo_empty in;
//          fifo_r_enable, dplus, dminus, tx_busy, tx_done out
// -----------------------------------------------------------------------------
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_tx_encoder_if.slave  bus
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // The state names the kind of bit currently on the line.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
`ifdef TX_CRC16_EN
        S_CRC,
`endif
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;      // cycle within the current bit period
    logic [3:0]       r_bit_idx;      // index of the current non-stuffed bit in its field
    logic [2:0]       r_ones;         // consecutive logical 1s emitted
    logic [7:0]       r_shift;        // remaining bits of the SYNC/data byte, LSB next
    logic             r_dplus;
    logic             r_dminus;
    logic             r_fifo_r_enable;
    logic             r_tx_busy;
    logic             r_tx_done;
`ifdef TX_CRC16_EN
    logic [15:0]      r_crc;

    // Reflected form of poly 0x8005 (0xA001): feeding data LSB first into a
    // right-shifting register is the bit-reversed image of the textbook
    // MSB-first division, so the register's LSB is the first CRC bit to send.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
`endif

    logic       w_bit_end;     // last cycle of a bit period: the line may change on this edge
    logic       w_stuff;       // next bit period carries a stuffed 0
    logic       w_bit;         // logical bit emitted at the next bit boundary
    logic       w_level_next;  // NRZI line level (1 = J) for w_bit
    logic [2:0] w_ones_next;

    assign w_bit_end = (r_clk_cnt == CNT_LAST);

    // Selects the next logical bit. It must follow the same branch choice as
    // the sequential block below, which decides where that bit comes from.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_stuff = 1'b0;
        w_bit   = 1'b0;                 // also the first SYNC bit when leaving IDLE
        case (r_state)
            S_SYNC, S_DATA: begin
                w_stuff = (r_ones == 3'd6);
                if (r_bit_idx != 4'd7) begin
                    w_bit = r_shift[0];
                end else if (!bus.fifo_empty) begin
                    w_bit = bus.fifo_r_data[0];   // first bit of the next byte
                end
`ifdef TX_CRC16_EN
                else begin
                    w_bit = ~r_crc[0];            // first CRC bit
                end
`endif
            end
`ifdef TX_CRC16_EN
            S_CRC: begin
                w_stuff = (r_ones == 3'd6);
                w_bit   = ~r_crc[0];
            end
`endif
            default: ;
        endcase
        if (w_stuff) begin
            w_bit = 1'b0;
        end
        // Outside SE0 the D+ register is the current line level (J = 1).
        w_level_next = w_bit ? r_dplus : ~r_dplus;
        w_ones_next  = w_bit ? (r_ones + 3'd1) : 3'd0;
    end

    // NOTE: the asynchronous reset branch lets n_rst drop the line to idle J
    // in the same cycle, without waiting for a clock edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= S_IDLE;
            r_clk_cnt       <= '0;
            r_bit_idx       <= '0;
            r_ones          <= '0;
            r_shift         <= '0;
            r_dplus         <= 1'b1;
            r_dminus        <= 1'b0;
            r_fifo_r_enable <= 1'b0;
            r_tx_busy       <= 1'b0;
            r_tx_done       <= 1'b0;
`ifdef TX_CRC16_EN
            r_crc           <= 16'hFFFF;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // branch reads the pre-edge values; later assignments to the same
            // register within this block win.
            r_fifo_r_enable <= 1'b0;
            r_tx_done       <= 1'b0;

            if (r_state == S_IDLE) begin
                if (bus.tx_start) begin
                    // The first SYNC bit (a 0) goes out on this edge.
                    r_state   <= S_SYNC;
                    r_tx_busy <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_shift   <= 8'h40;   // 0x80 with bit 0 already on the line
                    r_dplus   <= w_level_next;
                    r_dminus  <= ~w_level_next;
                    r_ones    <= 3'd0;
`ifdef TX_CRC16_EN
                    r_crc     <= 16'hFFFF;
`endif
                end
            end else if (!w_bit_end) begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end else begin
                r_clk_cnt <= '0;
                if (w_stuff) begin
                    // Stuffed 0: bit index and shift register stay put.
                    r_dplus  <= w_level_next;
                    r_dminus <= ~w_level_next;
                    r_ones   <= w_ones_next;
                end else begin
                    case (r_state)
                        S_SYNC, S_DATA: begin
                            if (r_bit_idx != 4'd7) begin
                                r_bit_idx <= r_bit_idx + 4'd1;
                                r_shift   <= r_shift >> 1;
                                r_dplus   <= w_level_next;
                                r_dminus  <= ~w_level_next;
                                r_ones    <= w_ones_next;
                            end else if (!bus.fifo_empty) begin
                                // Seamless load of the next byte; bit 0 goes
                                // straight out and the byte is popped.
                                r_state         <= S_DATA;
                                r_bit_idx       <= '0;
                                r_shift         <= {1'b0, bus.fifo_r_data[7:1]};
                                r_fifo_r_enable <= 1'b1;
                                r_dplus         <= w_level_next;
                                r_dminus        <= ~w_level_next;
                                r_ones          <= w_ones_next;
`ifdef TX_CRC16_EN
                                r_crc           <= crc16_byte(r_crc, bus.fifo_r_data);
`endif
                            end else begin
`ifdef TX_CRC16_EN
                                r_state   <= S_CRC;
                                r_bit_idx <= '0;
                                r_crc     <= r_crc >> 1;
                                r_dplus   <= w_level_next;
                                r_dminus  <= ~w_level_next;
                                r_ones    <= w_ones_next;
`else
                                r_state   <= S_EOP_SE0;
                                r_bit_idx <= '0;
                                r_ones    <= '0;
                                r_dplus   <= 1'b0;
                                r_dminus  <= 1'b0;
`endif
                            end
                        end
`ifdef TX_CRC16_EN
                        S_CRC: begin
                            if (r_bit_idx != 4'd15) begin
                                r_bit_idx <= r_bit_idx + 4'd1;
                                r_crc     <= r_crc >> 1;
                                r_dplus   <= w_level_next;
                                r_dminus  <= ~w_level_next;
                                r_ones    <= w_ones_next;
                            end else begin
                                r_state   <= S_EOP_SE0;
                                r_bit_idx <= '0;
                                r_ones    <= '0;
                                r_dplus   <= 1'b0;
                                r_dminus  <= 1'b0;
                            end
                        end
`endif
                        S_EOP_SE0: begin
                            if (r_bit_idx == 4'd0) begin
                                r_bit_idx <= 4'd1;       // second SE0 bit period
                            end else begin
                                r_state   <= S_EOP_J;
                                r_bit_idx <= '0;
                                r_dplus   <= 1'b1;
                                r_dminus  <= 1'b0;
                            end
                        end
                        S_EOP_J: begin
                            r_state   <= S_IDLE;
                            r_tx_busy <= 1'b0;
                            r_tx_done <= 1'b1;
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.dplus         = r_dplus;
    assign bus.dminus        = r_dminus;
    assign bus.fifo_r_enable = r_fifo_r_enable;
    assign bus.tx_busy       = r_tx_busy;
    assign bus.tx_done       = r_tx_done;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_encoder
//
// Drives usb_tx_encoder through its interface with a queue-backed FIFO and
// compares every cycle against a packet model built from the line-coding
// rules (bit list -> stuffing -> NRZI -> EOP). Captured mid-bit line levels
// are also decoded back into bytes independently of the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_tx_encoder;

    localparam int         CPB     = 8;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic clk = 1'b0;
    logic n_rst;

    usb_tx_encoder_if bus();

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [7:0] fifo_q[$];
    logic [1:0] exp_syms[$];   // expected line symbol per bit period
    int         exp_pops[$];   // bit periods whose first cycle carries a pop

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_fifo();
        bus.fifo_empty  = (fifo_q.size() == 0);
        bus.fifo_r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    function automatic bit is_pop_period(input int p);
        foreach (exp_pops[i]) if (exp_pops[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Reference packet: logical bit list, then stuffing and NRZI, then EOP.
    task automatic build_expected(input logic [7:0] payload[$]);
        bit         bits[$];
        bit         first[$];
        int         ones;
        logic [1:0] lvl;
`ifdef TX_CRC16_EN
        logic [15:0] c;
        bit          fb;
`endif
        exp_syms.delete();
        exp_pops.delete();
        for (int i = 0; i < 8; i++) begin
            bits.push_back(i == 7);          // SYNC 0x80 LSB first
            first.push_back(1'b0);
        end
        foreach (payload[b]) begin
            for (int i = 0; i < 8; i++) begin
                bits.push_back(payload[b][i]);
                first.push_back(i == 0);
            end
        end
`ifdef TX_CRC16_EN
        // MSB-first division by 0x8005; sending the complement MSB first is
        // the same as sending the reflected register LSB first.
        c = 16'hFFFF;
        foreach (payload[b]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ payload[b][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        for (int i = 15; i >= 0; i--) begin
            bits.push_back(~c[i]);
            first.push_back(1'b0);
        end
`endif
        ones = 0;
        lvl  = SYM_J;
        for (int i = 0; i < bits.size(); i++) begin
            if (first[i]) exp_pops.push_back(exp_syms.size());
            if (!bits[i]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
            exp_syms.push_back(lvl);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
                exp_syms.push_back(lvl);
                ones = 0;
            end
        end
        exp_syms.push_back(SYM_SE0);
        exp_syms.push_back(SYM_SE0);
        exp_syms.push_back(SYM_J);
    endtask

    // Independent receive-side view: NRZI decode, destuff, regroup into bytes.
    task automatic decode_check(input string name, input logic [1:0] seen[$],
                                input logic [7:0] payload[$]);
        logic [1:0] prev;
        int         ones;
        bit         b;
        bit         data[$];
        logic [7:0] byte_v;
        int         extra;
        prev = SYM_J;
        ones = 0;
        for (int i = 0; i < seen.size(); i++) begin
            if (seen[i] == SYM_SE0) break;
            b    = (seen[i] == prev);
            prev = seen[i];
            if (ones == 6) begin
                ones = 0;                   // stuffed bit dropped
                continue;
            end
            ones = b ? ones + 1 : 0;
            data.push_back(b);
        end
`ifdef TX_CRC16_EN
        extra = 16;
`else
        extra = 0;
`endif
        check({name, "/decoded_len"}, 32'(data.size()), 32'(8 + 8 * payload.size() + extra));
        if (data.size() >= 8 + 8 * payload.size()) begin
            for (int k = 0; k <= payload.size(); k++) begin
                for (int i = 0; i < 8; i++) byte_v[i] = data[8 * k + i];
                if (k == 0) check({name, "/decoded_sync"}, 32'(byte_v), 32'h80);
                else check($sformatf("%s/decoded_byte%0d", name, k - 1), 32'(byte_v), 32'(payload[k - 1]));
            end
        end
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check({name, "/idle"},
                  32'({bus.dplus, bus.dminus, bus.tx_busy, bus.tx_done, bus.fifo_r_enable}),
                  32'(5'b10000));
        end
    endtask

    // poke_m / abort_m: cycle (after the start edge) at which a stray
    // tx_start is pulsed / n_rst is asserted; -1 disables.
    task automatic run_packet(input string name, input logic [7:0] payload[$],
                              input int poke_m, input int abort_m);
        int         total_m;
        int         pops;
        logic [1:0] seen[$];
        logic [1:0] exp_line;
        bit         exp_pop;
        fifo_q = payload;
        update_fifo();
        build_expected(payload);
        total_m = CPB * exp_syms.size();
        pops    = 0;
        @(negedge clk);
        bus.tx_start = 1'b1;
        for (int m = 0; m <= total_m + 1; m++) begin
            @(negedge clk);
            bus.tx_start = (m == poke_m);
            if (m == abort_m) begin
                n_rst = 1'b0;
                #1;
                check($sformatf("%s/abort_line", name), 32'({bus.dplus, bus.dminus}), 32'(SYM_J));
                check($sformatf("%s/abort_busy", name), 32'(bus.tx_busy), 32'(0));
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check($sformatf("%s/abort_hold", name),
                          32'({bus.dplus, bus.dminus, bus.tx_busy, bus.tx_done, bus.fifo_r_enable}),
                          32'(5'b10000));
                end
                n_rst = 1'b1;
                fifo_q.delete();
                update_fifo();
                return;
            end
            exp_line = (m >= total_m) ? SYM_J : exp_syms[m / CPB];
            exp_pop  = (m < total_m) && (m % CPB == 0) && is_pop_period(m / CPB);
            check($sformatf("%s/line@%0d", name, m), 32'({bus.dplus, bus.dminus}), 32'(exp_line));
            check($sformatf("%s/busy@%0d", name, m), 32'(bus.tx_busy), 32'(m < total_m));
            check($sformatf("%s/done@%0d", name, m), 32'(bus.tx_done), 32'(m == total_m));
            check($sformatf("%s/pop@%0d", name, m), 32'(bus.fifo_r_enable), 32'(exp_pop));
            if (m < total_m && m % CPB == CPB / 2) seen.push_back({bus.dplus, bus.dminus});
            if (bus.fifo_r_enable) begin
                pops++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                update_fifo();
            end
        end
        check({name, "/pop_count"}, 32'(pops), 32'(payload.size()));
        decode_check(name, seen, payload);
    endtask

    initial begin
        logic [7:0] pl[$];
        int         len;

        n_rst           = 1'b0;
        bus.tx_start    = 1'b0;
        fifo_q.delete();
        update_fifo();
        repeat (3) @(negedge clk);
        check("reset_state",
              32'({bus.dplus, bus.dminus, bus.tx_busy, bus.tx_done, bus.fifo_r_enable}),
              32'(5'b10000));
        n_rst = 1'b1;
        idle_check("after_reset", 100);

        pl.delete();
        run_packet("empty", pl, -1, -1);
        idle_check("empty", 10);

        pl.delete(); pl.push_back(8'h00);
        run_packet("byte00", pl, -1, -1);
        idle_check("byte00", 10);

        pl.delete(); pl.push_back(8'hFF);
        run_packet("byteFF", pl, -1, -1);
        idle_check("byteFF", 10);

        pl.delete(); pl.push_back(8'hA5); pl.push_back(8'h3C);
        run_packet("a5_3c", pl, -1, -1);
        idle_check("a5_3c", 10);

        // Stray start request in the middle of the first data byte.
        pl.delete(); pl.push_back(8'h5A); pl.push_back(8'hFF);
        run_packet("start_ignored", pl, CPB * 10 + 3, -1);
        idle_check("start_ignored", 150);

        // Reset in the middle of the second data byte.
        pl.delete(); pl.push_back(8'h12); pl.push_back(8'h34);
        run_packet("reset_mid", pl, -1, CPB * 19 + 5);
        idle_check("reset_mid", 20);

        for (int r = 0; r < 5; r++) begin
            pl.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) pl.push_back(8'hFF);
                else pl.push_back(8'($urandom));
            end
            run_packet($sformatf("random%0d", r), pl, -1, -1);
            idle_check($sformatf("random%0d", r), 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
- Transmit-side line encoder for the USB full-speed path; counterpart of the receive decoder/FIFO chain.
- Pulls payload bytes from the transmit FIFO (first-word-fall-through) and drives a packet onto D+/D-:
  - SYNC
  - bytes LSB-first with bit stuffing and NRZI
  - EOP, then back to idle J.
- Sits between the transmit FIFO and the bus pad drivers.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per USB bit period (>=4).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- tx_start  input  1  one-cycle request to send a packet; sampled only in IDLE.
- fifo_r_data  input  8  head byte of the transmit FIFO (valid when fifo_empty=0).
- fifo_empty  input  1  transmit FIFO empty flag.
- fifo_r_enable  output  1  one-cycle pop strobe to the transmit FIFO.
- dplus  output  1  D+ line drive.
- dminus  output  1  D- line drive.
- tx_busy  output  1  high from the cycle after tx_start is accepted until tx_done.
- tx_done  output  1  one-cycle pulse when the packet finishes.

Behaviour:
- Reset (asynchronous, active-low):
  - dplus=1, dminus=0 (idle J).
  - fifo_r_enable=0, tx_busy=0, tx_done=0.
  - FSM=IDLE; bit counter, ones counter and shift register all cleared.
  - Reset mid-packet forces idle J immediately; no EOP is sent.
- Bit timing: a clock-cycle counter counts 0..CLKS_PER_BIT-1. The line changes only on the cycle the counter wraps, so each bit holds exactly CLKS_PER_BIT cycles.
- NRZI: the encoder tracks the last line level. A logical 0 toggles J<->K; a logical 1 holds. J = (dplus=1, dminus=0), K = (0,1), SE0 = (0,0).
- Bit stuffing:
  - A ones counter increments on each emitted logical 1 and clears on each emitted 0.
  - On reaching 6, the next bit period emits a stuffed 0 (toggle), clears the counter and does not advance the shift register.
  - Applies to SYNC, DATA and CRC bits, including after the final payload bit before EOP.
- FSM:
  - IDLE: line at J. On tx_start=1, go to SYNC. The first SYNC bit starts on the next cycle.
  - SYNC: emit 0x80 LSB-first (0000_0001) over 8 bit periods. The final 1 counts toward stuffing. Then:
    - fifo_empty=0: go to DATA.
    - fifo_empty=1: go to EOP_SE0 (or CRC with the optional feature).
  - DATA:
    - At the start of each byte, load fifo_r_data into the shift register and pulse fifo_r_enable for exactly that one cycle.
    - Emit 8 bits LSB-first, plus any stuffed bits.
    - After the 8th data bit (and any pending stuff bit), fifo_empty is sampled: 0 -> load the next byte seamlessly; 1 -> EOP_SE0 (or CRC).
  - EOP_SE0: SE0 for 2 bit periods.
  - EOP_J: J for 1 bit period. At its end: tx_done=1 for one cycle, tx_busy=0, go to IDLE.
- tx_start while tx_busy=1 is ignored.
- fifo_r_enable is never asserted while fifo_empty=1.

Optional Feature:
- TX_CRC16_EN defined:
  - CRC16 is computed over all payload bytes: polynomial 0x8005, register init 0xFFFF, bitwise LSB-first update.
  - After DATA (or directly after SYNC if the payload is empty), state CRC sends the ones-complement of the register, 16 bits, LSB-first, with stuffing and NRZI, then goes to EOP_SE0.
  - The CRC register is re-initialised on tx_start acceptance.
- TX_CRC16_EN undefined: no CRC state or logic; DATA/SYNC go straight to EOP_SE0.

Test Plan:
- Reset then idle, no tx_start for 100 cycles -> dplus=1, dminus=0, tx_busy=0, fifo_r_enable never asserted.
- CLKS_PER_BIT=8, fifo_empty=1, pulse tx_start ->
  - line: K,J,K,J,K,J,K,K (8 cycles each), then SE0 16 cycles, then J 8 cycles;
  - tx_done pulses once at cycle 88 after start; tx_busy high throughout.
- FIFO holds 0x00 -> one fifo_r_enable pulse at the first DATA cycle; data section = 8 consecutive toggles starting from K, i.e. J,K,J,K,J,K,J,K; then EOP.
- FIFO holds 0xFF -> the SYNC final 1 plus 5 data ones triggers a stuffed 0 after the 5th data bit; DATA lasts 9 bit periods (72 cycles) with a single toggle at bit 6.
- FIFO holds 0xA5,0x3C -> exactly 2 fifo_r_enable pulses, 8 bit periods apart; decoded bit stream (via the rx path) returns 0xA5,0x3C.
- tx_start pulsed mid-DATA -> ignored, no second packet. n_rst asserted mid-DATA -> J on the same cycle, tx_busy=0, no tx_done. With TX_CRC16_EN and empty payload -> 16 CRC bits of value 0x0000 sent before EOP.
